// File: rtl/fp16_dot_accumulator_pkg.sv
// fp_pkg: fp16/fp32 field constants, FSM state encoding and the exact fp16->fp32 widening
package fp_pkg;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP16_BIAS = 15;
  localparam int FP32_BIAS = 127;
  localparam int BIAS_DELTA = FP32_BIAS - FP16_BIAS;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic logic [31:0] f16_to_f32(input logic [15:0] h);
    logic [FP16_EXP_W-1:0] e;
    logic [FP16_FRAC_W-1:0] f;
    e = h[14:10];
    f = h[9:0];
    return e == '0 ? {h[15], 31'b0} :
           &e ? (f == '0 ? {h[15], {FP32_EXP_W{1'b1}}, {FP32_FRAC_W{1'b0}}} : FP32_QNAN) :
           {h[15], 8'(e) + 8'(BIAS_DELTA), f, 13'b0};
  endfunction
endpackage

// File: rtl/fp16_dot_accumulator_if.sv
// fp16_dot_accumulator_if: product input stream and group-result output stream
interface fp16_dot_accumulator_if #(parameter int CNT_W = 8);
  logic in_valid;
  logic in_ready;
  logic [15:0] in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_data;
  logic [CNT_W-1:0] out_count;
  modport master(output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data, out_count);
  modport slave(input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data, out_count);
endinterface

// File: rtl/fp16_dot_accumulator_add.sv
// fp32_add_rne: single-cycle fp32 adder, round-to-nearest-even, flush-to-zero, quiet-NaN on invalid
module fp32_add_rne import fp_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, up;
  logic [31:0] x, y;
  logic [7:0] d;
  logic [4:0] sh, lz;
  logic [23:0] my_full;
  logic [49:0] ext;
  logic [26:0] mx, my, norm;
  logic [27:0] raw;
  logic [24:0] rnd;
  logic signed [9:0] ex, e, ef;
  assign a_nan = &a[30:23] & |a[22:0];
  assign b_nan = &b[30:23] & |b[22:0];
  assign a_inf = &a[30:23] & ~|a[22:0];
  assign b_inf = &b[30:23] & ~|b[22:0];
  assign a_zero = a[30:23] == '0;
  assign b_zero = b[30:23] == '0;
  assign swap = (b_zero ? 31'b0 : b[30:0]) > (a_zero ? 31'b0 : a[30:0]);
  assign x = swap ? b : a;
  assign y = swap ? a : b;
  assign d = x[30:23] - y[30:23];
  assign mx = |x[30:23] ? {1'b1, x[22:0], 3'b0} : '0;
  assign my_full = |y[30:23] ? {1'b1, y[22:0]} : '0;
  // shifts past 26 only ever contribute to sticky
  assign sh = d > 8'd26 ? 5'd27 : d[4:0];
  assign ext = {my_full, 26'b0} >> sh;
  assign my = {ext[49:24], |ext[23:0]};
  assign raw = x[31] ^ y[31] ? {1'b0, mx} - {1'b0, my} : {1'b0, mx} + {1'b0, my};
  always_comb begin
    lz = '0;
    for (int i = 0; i < 27; i++) if (raw[i]) lz = 5'(26 - i);
  end
  assign norm = raw[27] ? {raw[27:2], raw[1] | raw[0]} : raw[26:0] << lz;
  assign ex = $signed({2'b0, x[30:23]});
  assign e = raw[27] ? ex + 10'sd1 : ex - $signed({5'b0, lz});
  assign up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign rnd = {1'b0, norm[26:3]} + 25'(up);
  assign ef = e + $signed({9'b0, rnd[24]});
  always_comb
    sum = a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31])) ? FP32_QNAN :
          a_inf ? a :
          b_inf ? b :
          a_zero & b_zero ? {a[31] & b[31], 31'b0} :
          raw == '0 ? 32'b0 :
          ef >= 10'sd255 ? {x[31], 8'hff, 23'b0} :
          ef < 10'sd1 ? {x[31], 31'b0} :
          {x[31], ef[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
endmodule

// File: rtl/fp16_dot_accumulator.sv
// fp16_dot_accumulator: sums an in_last-terminated group of fp16 products into an fp32 result
module fp16_dot_accumulator import fp_pkg::*; #(
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  fp16_dot_accumulator_if.slave s
);
  state_t state;
  logic [31:0] acc, conv, sum;
  logic [CNT_W-1:0] count;
  logic accept;
  assign conv = f16_to_f32(s.in_data);
  assign accept = s.in_valid & s.in_ready;
  assign s.in_ready = state != DONE;
  assign s.out_valid = state == DONE;
  assign s.out_data = acc;
  assign s.out_count = count;
  fp32_add_rne u_add (.a(acc), .b(conv), .sum(sum));
  // the first beat loads directly so a lone -0 keeps its sign
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
    end else if (accept) begin
      acc <= state == IDLE ? conv : sum;
      count <= state == IDLE ? CNT_W'(1) : &count ? count : count + 1'b1;
      state <= s.in_last ? DONE : ACCUM;
    end else if (state == DONE && s.out_ready) state <= IDLE;
endmodule

// File: tb/tb_fp16_dot_accumulator.sv
// tb_fp16_dot_accumulator: directed and random groups checked against a real-arithmetic model
module tb_fp16_dot_accumulator;
  logic clk = 0;
  logic rst = 1;
  int n_checks = 0;
  int n_fail = 0;
  logic exp_valid = 0;
  logic [31:0] exp_data = 0;
  logic [31:0] m_acc = 0;
  logic [7:0] exp_cnt = 0;
  logic [7:0] m_cnt = 0;
  bit open = 0;
  fp16_dot_accumulator_if #(.CNT_W(8)) bus();
  fp16_dot_accumulator #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    if (f[30:23] == 0) return $bitstoreal({f[31], 63'b0});
    return $bitstoreal({f[31], 11'(f[30:23]) - 11'd127 + 11'd1023, f[22:0], 29'b0});
  endfunction

  function automatic real h2r(input logic [15:0] h);
    if (h[14:10] == 0) return $bitstoreal({h[15], 63'b0});
    return $bitstoreal({h[15], 11'(h[14:10]) - 11'd15 + 11'd1023, h[9:0], 42'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int e;
    logic [24:0] m;
    logic up;
    b = $realtobits(r);
    if (b[62:52] == 0) return {b[63], 31'b0};
    e = int'(b[62:52]) - 1023 + 127;
    up = b[28] & ((|b[27:0]) | b[29]);
    m = {1'b0, 1'b1, b[51:29]} + 25'(up);
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    if (e >= 255) return {b[63], 8'hff, 23'b0};
    if (e < 1) return {b[63], 31'b0};
    return {b[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] conv_m(input logic [15:0] h);
    if (h[14:10] == 5'h1f) return h[9:0] == 0 ? {h[15], 8'hff, 23'b0} : 32'h7FC00000;
    return r2f(h2r(h));
  endfunction

  function automatic logic [31:0] add_m(input logic [31:0] a, input logic [31:0] b);
    bit an, bn, ai, bi;
    an = &a[30:23] && |a[22:0];
    bn = &b[30:23] && |b[22:0];
    ai = &a[30:23] && a[22:0] == 0;
    bi = &b[30:23] && b[22:0] == 0;
    if (an || bn) return 32'h7FC00000;
    if (ai && bi) return a[31] != b[31] ? 32'h7FC00000 : a;
    if (ai) return a;
    if (bi) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [15:0] rand_h();
    int r;
    logic s;
    r = $urandom_range(0, 79);
    s = 1'($urandom);
    if (r == 0) return {s, 5'h1f, 10'b0};
    if (r == 1) return {s, 5'h1f, 1'b1, 9'($urandom)};
    if (r == 2) return {s, 15'b0};
    if (r == 3) return {s, 5'b0, 10'($urandom)};
    return {s, 5'($urandom_range(8, 22)), 10'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_count", 32'(bus.out_count), 0);
      exp_valid = 0;
      open = 0;
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(!exp_valid));
      if (exp_valid) begin
        chk("out_data", bus.out_data, exp_data);
        chk("out_count", 32'(bus.out_count), 32'(exp_cnt));
      end
      if (bus.in_valid && !exp_valid) begin
        m_acc = open ? add_m(m_acc, conv_m(bus.in_data)) : conv_m(bus.in_data);
        m_cnt = !open ? 8'd1 : m_cnt == 8'hff ? m_cnt : m_cnt + 8'd1;
        open = 1;
        if (bus.in_last) begin
          exp_valid = 1;
          exp_data = m_acc;
          exp_cnt = m_cnt;
          open = 0;
        end
      end else if (exp_valid && bus.out_ready) exp_valid = 0;
    end
  end

  task automatic send(input logic [15:0] d, input logic l, output int g);
    g = 0;
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_last = l;
    @(negedge clk);
    while (!bus.in_ready && g < 50) begin
      g++;
      @(negedge clk);
    end
    chk("send_timeout", 32'(g >= 50), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.in_last = 0;
  endtask

  task automatic expect_result(input string nm, input logic [31:0] d, input logic [7:0] c, output int g);
    g = 0;
    @(negedge clk);
    while (!bus.out_valid && g < 50) begin
      g++;
      @(negedge clk);
    end
    chk({nm, "_valid"}, 32'(bus.out_valid), 1);
    chk({nm, "_data"}, bus.out_data, d);
    chk({nm, "_count"}, 32'(bus.out_count), 32'(c));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.in_last = 0;
    bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    send(16'h3C00, 1, g);
    expect_result("single", 32'h3F800000, 1, g);
    chk("single_latency", 32'(g), 0);
    send(16'h3C00, 0, g);
    send(16'h4000, 0, g);
    send(16'hC200, 0, g);
    send(16'h3800, 1, g);
    expect_result("four", 32'h3F000000, 4, g);
    send(16'h7C00, 0, g);
    send(16'hFC00, 1, g);
    expect_result("inf_minus_inf", 32'h7FC00000, 2, g);
    send(16'h7E00, 0, g);
    send(16'h3C00, 1, g);
    expect_result("nan_sticky", 32'h7FC00000, 2, g);
    send(16'h7800, 0, g);
    send(16'h1C00, 0, g);
    send(16'h1800, 1, g);
    expect_result("rne_tie", 32'h47000002, 3, g);
    send(16'h7800, 0, g);
    send(16'h1000, 1, g);
    expect_result("rne_down", 32'h47000000, 2, g);
    bus.out_ready = 0;
    send(16'h3C00, 1, g);
    expect_result("bp", 32'h3F800000, 1, g);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_data", bus.out_data, 32'h3F800000);
      chk("bp_count", 32'(bus.out_count), 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1;
    send(16'h4000, 1, g);
    chk("bp_accept_delay", 32'(g), 1);
    expect_result("after_bp", 32'h40000000, 1, g);
    send(16'h3C00, 0, g);
    send(16'h3C00, 0, g);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    send(16'h4000, 1, g);
    expect_result("after_rst", 32'h40000000, 1, g);
    for (int i = 0; i < 299; i++) send(16'h3C00, 0, g);
    send(16'h3C00, 1, g);
    expect_result("saturate", 32'h43960000, 8'hff, g);
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.in_data = rand_h();
      bus.in_last = ($urandom % 5) == 0;
      bus.out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
